sdram_req_arbiter: RTL

Shares the SDRAM controller's single toggle-handshake request port (bank 0/1 port) between up to four requesters: ROM download writer, sound CPU, NVRAM/hiscore engine, and a spare. Each requester uses a simple valid/done interface. The arbiter latches the winning request, toggles the controller's `req`, and waits for `ack` to match. It then returns read data with a one-cycle `done` pulse.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/sdram_req_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request arbiter: FSM state encoding and the latched command.
package sdram_arb_pkg;

    localparam int ARB_MAX_REQ = 4;
    localparam int ARB_AW      = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [1:0]        ds;
        logic [15:0]       d;
    } arb_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector over requesters 1..NREQ-1, searching upward from ptr_i.
// Requester 0 is never picked here; its fixed priority is applied by the parent.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          req0_unused;

    assign req0_unused = req_i[0];

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NREQ - 1; k++) begin
            // Candidate index wraps from NREQ-1 back to 1, skipping 0.
            sum = {1'b0, ptr_i} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NREQ)) begin
                sum = sum - (IW + 1)'(NREQ - 1);
            end
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one toggle-handshake SDRAM controller port among up to four valid/done requesters.
// Requester 0 has fixed priority; the rest are served round-robin.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 23,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   c_valid,
    input  logic [NREQ-1:0]   c_we,
    input  logic [NREQ*AW-1:0] c_addr,
    input  logic [NREQ*2-1:0] c_ds,
    input  logic [NREQ*16-1:0] c_d,
    output logic [NREQ-1:0]   c_done,
    output logic [15:0]       c_q,
    output logic              port_req,
    input  logic              port_ack,
    output logic              port_we,
    output logic [AW:1]       port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q,
    output logic              busy,
    output logic              stuck,
    output arb_state_t        dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t     state_q;
    logic [IW-1:0]  win_q, win_d;
    logic [IW-1:0]  rr_ptr_q;
    arb_cmd_t       cmd_q, cmd_d;
    logic           port_req_q;
    logic [NREQ-1:0] c_done_q;
    logic [15:0]    c_q_q;
    logic [CW-1:0]  cnt_q;
    logic           stuck_q;

    logic [NREQ-1:0] rr_grant;
    logic [IW-1:0]   rr_idx;
    logic            any_req;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i   (c_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    assign any_req = c_valid[0] | (|rr_grant);

    always_comb begin
        win_d       = c_valid[0] ? '0 : rr_idx;
        cmd_d.we    = c_we[win_d];
        cmd_d.addr  = ARB_AW'(c_addr[win_d*AW +: AW]);
        cmd_d.ds    = c_ds[win_d*2 +: 2];
        cmd_d.d     = c_d[win_d*16 +: 16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            rr_ptr_q   <= IW'(1);
            cmd_q      <= '0;
            // Resync to the controller so leaving reset never looks like a new request.
            port_req_q <= port_ack;
            c_done_q   <= '0;
            c_q_q      <= '0;
            cnt_q      <= '0;
            stuck_q    <= 1'b0;
        end else begin
            c_done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        win_q   <= win_d;
                        cmd_q   <= cmd_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    port_req_q <= ~port_req_q;
                    cnt_q      <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q != CW'(TIMEOUT)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Flag only: the handshake is still owed, so keep waiting for ack.
                    if (cnt_q >= CW'(TIMEOUT - 1)) begin
                        stuck_q <= 1'b1;
                    end
                    if (port_ack == port_req_q) begin
                        if (!cmd_q.we) begin
                            c_q_q <= port_q;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    c_done_q[win_q] <= 1'b1;
                    if (win_q != '0) begin
                        rr_ptr_q <= (win_q == IW'(NREQ - 1)) ? IW'(1) : win_q + 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c_done    = c_done_q;
    assign c_q       = c_q_q;
    assign port_req  = port_req_q;
    assign port_we   = cmd_q.we;
    assign port_a    = AW'(cmd_q.addr);
    assign port_ds   = cmd_q.ds;
    assign port_d    = cmd_q.d;
    assign busy      = (state_q != ST_IDLE);
    assign stuck     = stuck_q;
    assign dbg_state = state_q;

endmodule
